sm3_msg_expnd_core: RTL



---
 rtl/sm3_pkg.sv | 40 ++++
 rtl/sm3_expnd_ceil_comb.sv | 31 +++
 rtl/sm3_msg_expnd_core.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sm3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_pkg
//  Description : Shared SM3 definitions for the message-expansion and
//                compression cores: block/round sizes, the 32-bit word type,
//                the rotate and P1 permutation helpers, and the expansion
//                FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package sm3_pkg;

    localparam int unsigned SM3_BLK_WRDS = 16;
    localparam int unsigned SM3_RND_NUM  = 64;

    typedef logic [31:0] sm3_wrd_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        EXPND = 2'd1,
        GAP   = 2'd2
    } sm3_expnd_st_e;

    // 32-bit rotate left. Only the low five bits of the amount matter.
    function automatic sm3_wrd_t rotl32(input sm3_wrd_t x, input int unsigned n);
        logic [4:0] amt;
        amt = n[4:0];
        if (amt == 5'd0) begin
            rotl32 = x;
        end else begin
            rotl32 = (x << amt) | (x >> (6'd32 - {1'b0, amt}));
        end
    endfunction

    // SM3 permutation P1(x) = x ^ (x <<< 15) ^ (x <<< 23).
    function automatic sm3_wrd_t sm3_p1(input sm3_wrd_t x);
        sm3_p1 = x ^ rotl32(x, 15) ^ rotl32(x, 23);
    endfunction

endpackage : sm3_pkg
`default_nettype wire

// File: rtl/sm3_expnd_ceil_comb.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_expnd_ceil_comb
//  Description : Combinational generator of the next expanded word.
//                With the window holding W[j..j+15] (slot 0 = W[j]) this
//                produces W[j+16] =
//                  P1(W[j] ^ W[j+7] ^ (W[j+13] <<< 15)) ^ (W[j+3] <<< 7) ^ W[j+10]
//  Ports       : wrd0_i, wrd3_i, wrd7_i, wrd10_i, wrd13_i  window slots (in)
//                wrd_nxt_o                                 W[j+16]      (out)
//  Revision    : 1.0  initial release
// ============================================================================
module sm3_expnd_ceil_comb
    import sm3_pkg::*;
(
    input  logic [31:0] wrd0_i,
    input  logic [31:0] wrd3_i,
    input  logic [31:0] wrd7_i,
    input  logic [31:0] wrd10_i,
    input  logic [31:0] wrd13_i,
    output logic [31:0] wrd_nxt_o
);

    sm3_wrd_t w_p1_in;

    always_comb begin
        w_p1_in   = wrd0_i ^ wrd7_i ^ rotl32(wrd13_i, 15);
        wrd_nxt_o = sm3_p1(w_p1_in) ^ rotl32(wrd3_i, 7) ^ wrd10_i;
    end

endmodule : sm3_expnd_ceil_comb
`default_nettype wire

// File: rtl/sm3_msg_expnd_core.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_msg_expnd_core
//  Description : SM3 message-expansion core. Loads a 16-word block over a
//                valid/ready handshake, then streams 64 rounds of {Wj, Wj'}
//                one per cycle, followed by BLK_GAP idle cycles that the
//                compression core uses for its V-xor / IV reload.
//  Ports       : clk, rst_n (async, active-low), clr_i (sync abort)
//                blk_wrd_i / blk_wrd_vld_i / blk_lst_i / blk_wrd_rdy_o  input
//                expnd_otpt_{wj,wjj,lst,vld,rnd}_o                     output
//  Revision    : 1.0  initial release
// ============================================================================
module sm3_msg_expnd_core
    import sm3_pkg::*;
#(
    parameter int unsigned BLK_GAP = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic [31:0] blk_wrd_i,
    input  logic        blk_wrd_vld_i,
    input  logic        blk_lst_i,
    output logic        blk_wrd_rdy_o,
    output logic [31:0] expnd_otpt_wj_o,
    output logic [31:0] expnd_otpt_wjj_o,
    output logic        expnd_otpt_lst_o,
    output logic        expnd_otpt_vld_o,
    output logic [5:0]  expnd_otpt_rnd_o
);

    // The gap counter is 3 bits wide and the compression core needs at
    // least two idle cycles, so only 2..7 is meaningful.
    generate
        if ((BLK_GAP < 2) || (BLK_GAP > 7)) begin : g_blk_gap_illegal
            $error("sm3_msg_expnd_core: BLK_GAP must be in 2..7");
        end
    endgenerate

    localparam logic [2:0] c_gap_last = 3'(BLK_GAP - 1);
    localparam logic [3:0] c_wrd_last = 4'(SM3_BLK_WRDS - 1);
    localparam logic [5:0] c_rnd_last = 6'(SM3_RND_NUM - 1);

    sm3_expnd_st_e state_q, state_d;
    logic [3:0]    cnt_q,   cnt_d;
    logic [5:0]    rnd_q,   rnd_d;
    logic [2:0]    gap_q,   gap_d;
    logic          lst_q,   lst_d;
    sm3_wrd_t      win_q [SM3_BLK_WRDS];
    sm3_wrd_t      win_d [SM3_BLK_WRDS];

    sm3_wrd_t      wj_q,    wj_d;
    sm3_wrd_t      wjj_q,   wjj_d;
    logic          vld_q,   vld_d;
    logic          olst_q,  olst_d;
    logic [5:0]    ornd_q,  ornd_d;

    sm3_wrd_t      w_wrd_nxt;

    sm3_expnd_ceil_comb u_ceil (
        .wrd0_i    (win_q[0]),
        .wrd3_i    (win_q[3]),
        .wrd7_i    (win_q[7]),
        .wrd10_i   (win_q[10]),
        .wrd13_i   (win_q[13]),
        .wrd_nxt_o (w_wrd_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        gap_d   = gap_q;
        lst_d   = lst_q;
        win_d   = win_q;
        wj_d    = wj_q;
        wjj_d   = wjj_q;
        vld_d   = 1'b0;
        olst_d  = 1'b0;
        ornd_d  = ornd_q;

        case (state_q)
            LOAD: begin
                if (blk_wrd_vld_i) begin
                    win_d[cnt_q] = blk_wrd_i;
                    if (cnt_q == c_wrd_last) begin
                        lst_d   = blk_lst_i;
                        cnt_d   = 4'd0;
                        rnd_d   = 6'd0;
                        state_d = EXPND;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            EXPND: begin
                wj_d   = win_q[0];
                wjj_d  = win_q[0] ^ win_q[4];
                vld_d  = 1'b1;
                olst_d = lst_q && (rnd_q == c_rnd_last);
                ornd_d = rnd_q;
                for (int i = 0; i < SM3_BLK_WRDS - 1; i++) begin
                    win_d[i] = win_q[i + 1];
                end
                win_d[SM3_BLK_WRDS - 1] = w_wrd_nxt;
                rnd_d = rnd_q + 6'd1;
                if (rnd_q == c_rnd_last) begin
                    gap_d   = 3'd0;
                    state_d = GAP;
                end
            end

            GAP: begin
                if (gap_q == c_gap_last) begin
                    lst_d   = 1'b0;
                    state_d = LOAD;
                end else begin
                    gap_d = gap_q + 3'd1;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase

        // Abort wins over everything, including a word offered this cycle.
        if (clr_i) begin
            state_d = LOAD;
            cnt_d   = 4'd0;
            rnd_d   = 6'd0;
            gap_d   = 3'd0;
            lst_d   = 1'b0;
            vld_d   = 1'b0;
            olst_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= 4'd0;
            rnd_q   <= 6'd0;
            gap_q   <= 3'd0;
            lst_q   <= 1'b0;
            for (int i = 0; i < SM3_BLK_WRDS; i++) begin
                win_q[i] <= '0;
            end
            wj_q    <= '0;
            wjj_q   <= '0;
            vld_q   <= 1'b0;
            olst_q  <= 1'b0;
            ornd_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            gap_q   <= gap_d;
            lst_q   <= lst_d;
            win_q   <= win_d;
            wj_q    <= wj_d;
            wjj_q   <= wjj_d;
            vld_q   <= vld_d;
            olst_q  <= olst_d;
            ornd_q  <= ornd_d;
        end
    end

    assign blk_wrd_rdy_o    = (state_q == LOAD);
    assign expnd_otpt_wj_o  = wj_q;
    assign expnd_otpt_wjj_o = wjj_q;
    assign expnd_otpt_lst_o = olst_q;
    assign expnd_otpt_vld_o = vld_q;
    assign expnd_otpt_rnd_o = ornd_q;

endmodule : sm3_msg_expnd_core
`default_nettype wire
